// File: rtl/cpc_ramx_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpc_ramx_ctrl: CPC RAM expansion banking (config capture, bus FSM, map)   |
// | Optional macro RAMX_SHADOW_BANK_EN: 464 shadow of 6128 RAM in top bank.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cpc_ramx_ctrl #(
  parameter int BANK_BITS = 3
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 iorq_b,
  input  logic                 mreq_b,
  input  logic                 wr_b,
  input  logic                 rfsh_b,
  input  logic                 adr15,
  input  logic                 adr14,
  input  logic [2:0]           adr_io,
  input  logic [7:0]           data,
  input  logic                 mode464,
  output logic                 ramcs_b,
  output logic                 ramdis,
  output logic                 ramwe_b,
  output logic [BANK_BITS+1:0] ramadrhi,
  output logic [BANK_BITS+2:0] cfg_q
);

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_ACTIVE = 1'b1;
  localparam logic [BANK_BITS-1:0] TOP_BANK = '1;

  logic                 state;
  logic                 state_nxt;
  logic [BANK_BITS+2:0] pending;
  logic                 pend_v;
  logic                 io_armed;
  logic                 hit;
  logic                 io_cap;
  logic                 commit;
  logic [BANK_BITS-1:0] wr_bank;
  logic [BANK_BITS-1:0] cur_bank;
  logic [2:0]           cur_scheme;
  logic [1:0]           blk;
  logic                 map_hit;
  logic [1:0]           map_blk;
  logic [BANK_BITS-1:0] map_bank;
  logic [BANK_BITS+1:0] map_adr;
  logic                 unused_inputs;

  assign io_cap     = io_armed && !iorq_b && !wr_b && !adr15 && (data[7:6] == 2'b11);
  assign commit     = (state == ST_IDLE) && pend_v;
  assign cur_bank   = cfg_q[BANK_BITS+2:3];
  assign cur_scheme = cfg_q[2:0];
  assign blk        = {adr15, adr14};
  assign ramwe_b    = wr_b;

  generate
    if (BANK_BITS == 3) begin : g_bank_narrow
      assign wr_bank = data[5:3];
    end else begin : g_bank_wide
      assign wr_bank = {adr_io[BANK_BITS-4:0], data[5:3]};
    end
  endgenerate

  assign unused_inputs = ^{adr_io, mode464};

  // Mapping is evaluated against the committed config at access start.
  always_comb begin
    map_hit  = 1'b0;
    map_blk  = blk;
    map_bank = cur_bank;
    case (cur_scheme)
      3'd0:       map_hit = 1'b0;
      3'd1, 3'd3: map_hit = (blk == 2'b11);
      3'd2:       map_hit = 1'b1;
      default: begin
        if (blk == 2'b01) begin
          map_hit = 1'b1;
          map_blk = cur_scheme[1:0];
        end
      end
    endcase
`ifdef RAMX_SHADOW_BANK_EN
    if (mode464) begin
      if (map_hit && (cur_bank == TOP_BANK)) begin
        map_bank = TOP_BANK - 1'b1;
      end
      if (!map_hit) begin
        map_hit  = 1'b1;
        map_bank = TOP_BANK;
        map_blk  = blk;
      end
    end
`endif
    map_adr = {map_bank, map_blk};
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (!mreq_b && rfsh_b) state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (mreq_b)            state_nxt = ST_IDLE;
      default:                          state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ramcs_b = 1'b1;
    ramdis  = 1'b0;
    if ((state == ST_ACTIVE) && hit) begin
      ramdis  = 1'b1;
      ramcs_b = mreq_b;
    end
  end

  // A capture on a commit edge lands in pending after the old value commits.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      cfg_q    <= '0;
      pending  <= '0;
      pend_v   <= 1'b0;
      io_armed <= 1'b1;
      hit      <= 1'b0;
      ramadrhi <= '0;
    end else begin
      if (iorq_b)      io_armed <= 1'b1;
      else if (io_cap) io_armed <= 1'b0;
      if (commit) begin
        cfg_q  <= pending;
        pend_v <= 1'b0;
      end
      if (io_cap) begin
        pending <= {wr_bank, data[2:0]};
        pend_v  <= 1'b1;
      end
      if ((state == ST_IDLE) && (state_nxt == ST_ACTIVE)) begin
        hit      <= map_hit;
        ramadrhi <= map_adr;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpc_ramx_ctrl.sv
`default_nettype none
// Directed bench for cpc_ramx_ctrl: BANK_BITS=3 main instance, BANK_BITS=5 for wide banks.
module tb_cpc_ramx_ctrl;

  logic       clk = 1'b0;
  logic       reset_b, iorq_b, mreq_b, wr_b, rfsh_b, adr15, adr14, mode464;
  logic [2:0] adr_io;
  logic [7:0] data;
  logic       ramcs_b, ramdis, ramwe_b;
  logic [4:0] ramadrhi;
  logic [5:0] cfg_q;
  logic       ramcs5_b, ramdis5, ramwe5_b;
  logic [6:0] ramadrhi5;
  logic [7:0] cfg5_q;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpc_ramx_ctrl #(.BANK_BITS(3)) u_dut3 (
    .clk(clk), .reset_b(reset_b), .iorq_b(iorq_b), .mreq_b(mreq_b), .wr_b(wr_b),
    .rfsh_b(rfsh_b), .adr15(adr15), .adr14(adr14), .adr_io(adr_io), .data(data),
    .mode464(mode464), .ramcs_b(ramcs_b), .ramdis(ramdis), .ramwe_b(ramwe_b),
    .ramadrhi(ramadrhi), .cfg_q(cfg_q));

  cpc_ramx_ctrl #(.BANK_BITS(5)) u_dut5 (
    .clk(clk), .reset_b(reset_b), .iorq_b(iorq_b), .mreq_b(mreq_b), .wr_b(wr_b),
    .rfsh_b(rfsh_b), .adr15(adr15), .adr14(adr14), .adr_io(adr_io), .data(data),
    .mode464(mode464), .ramcs_b(ramcs5_b), .ramdis(ramdis5), .ramwe_b(ramwe5_b),
    .ramadrhi(ramadrhi5), .cfg_q(cfg5_q));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic io_wr(input logic a15, input logic [2:0] aio, input logic [7:0] d);
    iorq_b = 1'b0; wr_b = 1'b0; adr15 = a15; adr_io = aio; data = d;
    step();
    iorq_b = 1'b1; wr_b = 1'b1;
    step();
  endtask

  task automatic mem_start(input logic a15, input logic a14);
    adr15 = a15; adr14 = a14; mreq_b = 1'b0;
    step();
  endtask

  task automatic mem_end();
    mreq_b = 1'b1;
    step();
  endtask

  initial begin
    reset_b = 1'b0; iorq_b = 1'b1; mreq_b = 1'b1; wr_b = 1'b1; rfsh_b = 1'b1;
    adr15 = 1'b0; adr14 = 1'b0; adr_io = 3'b000; data = 8'h00; mode464 = 1'b0;
    #3;
    chk("rst_ramcs_b", ramcs_b, 1);
    chk("rst_ramdis", ramdis, 0);
    chk("rst_cfg_q", cfg_q, 0);
    chk("rst_ramadrhi", ramadrhi, 0);
    step(); step();
    reset_b = 1'b1;
    step();

    // Read at 0xC000 with reset config: internal RAM
    mem_start(1'b1, 1'b1);
    chk("c000_ramcs_b", ramcs_b, 1);
    chk("c000_ramdis", ramdis, 0);
    chk("c000_cfg_q", cfg_q, 0);
    mem_end();

    // IOWR 0x7F00 data 0xCA: bank 001 scheme 2; read 0x8123
    io_wr(1'b0, 3'b111, 8'hCA);
    chk("ca_cfg_q", cfg_q, 6'b001010);
    chk("ca_ramwe_b", ramwe_b, 1);
    mem_start(1'b1, 1'b0);
    chk("8123_ramcs_b", ramcs_b, 0);
    chk("8123_ramdis", ramdis, 1);
    chk("8123_ramadrhi", ramadrhi, 5'b00110);
    mreq_b = 1'b1;
    #1;
    chk("8123_cs_gated", ramcs_b, 1);
    chk("8123_dis_held", ramdis, 1);
    step();
    chk("8123_idle_dis", ramdis, 0);
    chk("8123_adr_hold", ramadrhi, 5'b00110);
    mem_start(1'b0, 1'b0);
    chk("0000_s2_adr", ramadrhi, 5'b00100);
    mem_end();

    // Wide bank: adr_io=101 data 0xFC, read 0x4000
    io_wr(1'b0, 3'b101, 8'hFC);
    chk("fc_cfg5", cfg5_q, 8'b01111100);
    chk("fc_cfg3", cfg_q, 6'b111100);
    mem_start(1'b0, 1'b1);
    chk("4000_adr5", ramadrhi5, 7'b0111100);
    chk("4000_dis5", ramdis5, 1);
    chk("4000_adr3", ramadrhi, 5'b11100);
    mem_end();
    mem_start(1'b1, 1'b1);
    chk("c000_s4_dis", ramdis, 0);
    chk("c000_s4_cs", ramcs_b, 1);
    mem_end();

    // Config write during an active access is deferred
    io_wr(1'b0, 3'b000, 8'hC1);
    chk("c1_cfg", cfg_q, 6'b000001);
    mem_start(1'b1, 1'b1);
    chk("c1_c000_adr", ramadrhi, 5'b00011);
    chk("c1_c000_cs", ramcs_b, 0);
    iorq_b = 1'b0; wr_b = 1'b0; adr15 = 1'b0; data = 8'hC7;
    step();
    chk("defer_cfg_a", cfg_q, 6'b000001);
    chk("defer_adr", ramadrhi, 5'b00011);
    iorq_b = 1'b1; wr_b = 1'b1;
    step();
    chk("defer_cfg_b", cfg_q, 6'b000001);
    mreq_b = 1'b1;
    step();
    chk("defer_exit_edge", cfg_q, 6'b000001);
    step();
    chk("defer_commit", cfg_q, 6'b000111);

    // I/O cycle held three edges captures once
    iorq_b = 1'b0; wr_b = 1'b0; adr15 = 1'b0; data = 8'hC2;
    step();
    data = 8'hC3;
    step(); step();
    iorq_b = 1'b1; wr_b = 1'b1;
    step();
    chk("hold3_single", cfg_q, 6'b000010);
    io_wr(1'b1, 3'b000, 8'hC5);
    chk("adr15_ignored", cfg_q, 6'b000010);
    io_wr(1'b0, 3'b000, 8'h85);
    chk("d76_ignored", cfg_q, 6'b000010);

    // Refresh never leaves IDLE
    adr15 = 1'b1; adr14 = 1'b1; mreq_b = 1'b0; rfsh_b = 1'b0;
    step();
    chk("rfsh_cs", ramcs_b, 1);
    chk("rfsh_dis", ramdis, 0);
    mreq_b = 1'b1; rfsh_b = 1'b1;
    step();
    mem_start(1'b0, 1'b1);
    chk("post_rfsh_adr", ramadrhi, 5'b00001);
    chk("post_rfsh_cs", ramcs_b, 0);

    // Reset mid-access with a pending config
    iorq_b = 1'b0; wr_b = 1'b0; adr15 = 1'b0; data = 8'hC5;
    step();
    iorq_b = 1'b1; wr_b = 1'b1;
    #2;
    reset_b = 1'b0;
    #1;
    chk("midrst_cs", ramcs_b, 1);
    chk("midrst_dis", ramdis, 0);
    chk("midrst_cfg", cfg_q, 0);
    chk("midrst_adr", ramadrhi, 0);
    step();
    reset_b = 1'b1; mreq_b = 1'b1;
    step(); step();
    chk("pending_discard", cfg_q, 0);

    // 464 host mode
    mode464 = 1'b1;
    mem_start(1'b0, 1'b0);
`ifdef RAMX_SHADOW_BANK_EN
    chk("m464_s0_dis", ramdis, 1);
    chk("m464_s0_adr", ramadrhi, 5'b11100);
`else
    chk("m464_s0_dis", ramdis, 0);
    chk("m464_s0_cs", ramcs_b, 1);
`endif
    mem_end();
    io_wr(1'b0, 3'b000, 8'hFA);
    chk("fa_cfg", cfg_q, 6'b111010);
    mem_start(1'b0, 1'b1);
    chk("m464_top_dis", ramdis, 1);
`ifdef RAMX_SHADOW_BANK_EN
    chk("m464_top_adr", ramadrhi, 5'b11001);
`else
    chk("m464_top_adr", ramadrhi, 5'b11101);
`endif
    mem_end();
    mode464 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
